// File: rtl/simd_csa_resolve.sv
// -----------------------------------------------------------------------------
// simd_csa_resolve
//   Resolves a carry-save (ps, sc) pair from simd_muland into a final SIMD
//   result. Arithmetic mode adds lane-wise mod 2^lane_width. Boolean mode
//   XOR-combines the two shares. The carry-propagate add is split into
//   CHUNK-bit pieces, one piece per pipeline stage. Carries are cut at every
//   lane boundary.
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     in_valid_i/in_ready_o input handshake
//     ps_i, sc_i            partial-sum / aligned shifted-carry vectors
//     mode_i                3'b100 arithmetic, 3'b010 boolean
//     width_i               lane width 000=32, 001=64, 011=128, 111=256
//     out_valid_o/out_ready_i output handshake
//     res_o                 resolved result
//     cout_o                per-lane carry-out, at the lane's top 32-bit segment
//     err_o                 sticky: illegal mode/width accepted
// -----------------------------------------------------------------------------

// One chunk of the carry-propagate adder. The chunk is built from two 32-bit
// halves, so CHUNK must be 64. That way a 32-bit lane boundary can cut the
// carry in the middle of the chunk.
module simd_csa_chunk #(
   parameter int CHUNK = 64,
   parameter int K     = 0          // chunk index within the datapath
) (
   input  logic [CHUNK-1:0] ps_i,
   input  logic [CHUNK-1:0] sc_i,
   input  logic             carry_i,    // carry out of chunk K-1
   input  logic             arith_i,
   input  logic [1:0]       lw_i,       // 0:32 1:64 2:128 3:256
   output logic [CHUNK-1:0] res_o,
   output logic             mid_cout_o, // carry out of a 32-bit lane in the low half
   output logic             carry_o,    // raw carry out of the chunk top bit
   output logic             lane_end_o  // chunk top bit is a lane MSB
);
   localparam int HALF = CHUNK / 2;

   logic            lw32;
   logic            start_bnd;
   logic            cin_lo;
   logic            c_mid;
   logic [HALF:0]   sum_lo;
   logic [HALF:0]   sum_hi;

   assign lw32 = (lw_i == 2'd0);

   // Is the chunk's bottom bit the start of a lane? Is its top bit the end of a lane?
   always_comb begin
      start_bnd  = 1'b1;
      lane_end_o = 1'b1;
      case (lw_i)
         2'd2:    begin start_bnd = ((K % 2) == 0); lane_end_o = ((K % 2) == 1); end
         2'd3:    begin start_bnd = ((K % 4) == 0); lane_end_o = ((K % 4) == 3); end
         default: begin start_bnd = 1'b1;           lane_end_o = 1'b1;           end
      endcase
   end

   assign cin_lo = carry_i & ~start_bnd;
   assign sum_lo = {1'b0, ps_i[HALF-1:0]} + {1'b0, sc_i[HALF-1:0]} + {{HALF{1'b0}}, cin_lo};
   // With 32-bit lanes, bit 32 of the chunk starts a new lane.
   assign c_mid  = sum_lo[HALF] & ~lw32;
   assign sum_hi = {1'b0, ps_i[CHUNK-1:HALF]} + {1'b0, sc_i[CHUNK-1:HALF]} + {{HALF{1'b0}}, c_mid};

   assign res_o      = arith_i ? {sum_hi[HALF-1:0], sum_lo[HALF-1:0]} : (ps_i ^ sc_i);
   assign mid_cout_o = arith_i & lw32 & sum_lo[HALF];
   assign carry_o    = arith_i & sum_hi[HALF];
endmodule

module simd_csa_resolve #(
   parameter int W     = 256,
   parameter int CHUNK = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [W-1:0]   ps_i,
   input  logic [W-1:0]   sc_i,
   input  logic [2:0]     mode_i,
   input  logic [2:0]     width_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [W-1:0]   res_o,
   output logic [W/32-1:0] cout_o,
   output logic           err_o
);
   localparam int NS  = W / CHUNK;
   localparam int SEG = CHUNK / 32;   // cout bits per chunk

   logic            adv;
   logic [NS:1]     vld_pipe;

   // Input decode. An illegal mode or width falls back to boolean.
   logic            width_ok;
   logic            in_arith;
   logic            in_legal;
   logic [1:0]      in_lw;

   always_comb begin
      width_ok = 1'b1;
      in_lw    = 2'd0;
      case (width_i)
         3'b000:  in_lw = 2'd0;
         3'b001:  in_lw = 2'd1;
         3'b011:  in_lw = 2'd2;
         3'b111:  in_lw = 2'd3;
         default: width_ok = 1'b0;
      endcase
   end

   assign in_arith = (mode_i == 3'b100) & width_ok;
   assign in_legal = in_arith | (mode_i == 3'b010);

   // A single advance enable for the whole pipeline. It goes combinationally from out_ready_i.
   assign out_valid_o = vld_pipe[NS];
   assign in_ready_o  = ~out_valid_o | out_ready_i;
   assign adv         = in_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i)      vld_pipe <= '0;
      else if (adv)   vld_pipe <= {vld_pipe[NS-1:1], in_valid_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                                 err_o <= 1'b0;
      else if (in_valid_i & in_ready_o & ~in_legal) err_o <= 1'b1;
   end

   // Per-stage control. Each signal has an _s copy seen by stage j and a
   // registered _q copy at the output of stage j.
   logic [NS-1:0]        arith_s;
   logic [NS-1:0]        carry_s;
   logic [NS-1:0][1:0]   lw_s;
   logic [NS-1:0]        carry_n;
   logic [NS-2:0]        arith_q;
   logic [NS-2:0]        carry_q;
   logic [NS-2:0][1:0]   lw_q;

   assign arith_s[0] = in_arith;
   assign lw_s[0]    = in_lw;
   assign carry_s[0] = 1'b0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         arith_q <= '0;
         lw_q    <= '0;
         carry_q <= '0;
      end else if (adv) begin
         for (int j = 0; j < NS-1; j++) begin
            arith_q[j] <= arith_s[j];
            lw_q[j]    <= lw_s[j];
            carry_q[j] <= carry_n[j];
         end
      end
   end

   for (genvar j = 0; j < NS; j++) begin : g_ch
      localparam int D = NS - j;   // result delay so every chunk exits aligned

      logic [CHUNK-1:0]          ps_at;
      logic [CHUNK-1:0]          sc_at;
      logic [CHUNK-1:0]          rc;
      logic                      mid_c;
      logic                      lane_end;
      logic [D-1:0][CHUNK-1:0]   res_dl;
      logic [D-1:0][SEG-1:0]     cout_dl;

      if (j == 0) begin : g_nodly
         assign ps_at = ps_i[CHUNK-1:0];
         assign sc_at = sc_i[CHUNK-1:0];
      end else begin : g_dly
         // Operand skew: chunk j waits j stages for the carry from below.
         logic [j-1:0][CHUNK-1:0] ps_dl;
         logic [j-1:0][CHUNK-1:0] sc_dl;

         assign arith_s[j] = arith_q[j-1];
         assign lw_s[j]    = lw_q[j-1];
         assign carry_s[j] = carry_q[j-1];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               ps_dl <= '0;
               sc_dl <= '0;
            end else if (adv) begin
               ps_dl[0] <= ps_i[j*CHUNK +: CHUNK];
               sc_dl[0] <= sc_i[j*CHUNK +: CHUNK];
               for (int m = 1; m < j; m++) begin
                  ps_dl[m] <= ps_dl[m-1];
                  sc_dl[m] <= sc_dl[m-1];
               end
            end
         end

         assign ps_at = ps_dl[j-1];
         assign sc_at = sc_dl[j-1];
      end

      simd_csa_chunk #(.CHUNK(CHUNK), .K(j)) u_chunk (
         .ps_i       (ps_at),
         .sc_i       (sc_at),
         .carry_i    (carry_s[j]),
         .arith_i    (arith_s[j]),
         .lw_i       (lw_s[j]),
         .res_o      (rc),
         .mid_cout_o (mid_c),
         .carry_o    (carry_n[j]),
         .lane_end_o (lane_end)
      );

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            res_dl  <= '0;
            cout_dl <= '0;
         end else if (adv) begin
            res_dl[0]  <= rc;
            cout_dl[0] <= {carry_n[j] & lane_end, mid_c};
            for (int m = 1; m < D; m++) begin
               res_dl[m]  <= res_dl[m-1];
               cout_dl[m] <= cout_dl[m-1];
            end
         end
      end

      assign res_o[j*CHUNK +: CHUNK] = res_dl[D-1];
      assign cout_o[j*SEG +: SEG]    = cout_dl[D-1];
   end
endmodule

// File: tb/tb_simd_csa_resolve.sv
module tb_simd_csa_resolve;
   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] ps;
   logic [255:0] sc;
   logic [2:0]   mode;
   logic [2:0]   width;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] res;
   logic [7:0]   cout;
   logic         err;

   int checks   = 0;
   int failures = 0;

   simd_csa_resolve dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .ps_i        (ps),
      .sc_i        (sc),
      .mode_i      (mode),
      .width_i     (width),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .res_o       (res),
      .cout_o      (cout),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: a bit-serial ripple add with the carry zeroed at each lane start.
   function automatic void model(input logic [255:0] p, input logic [255:0] s,
                                 input logic [2:0] m, input logic [2:0] w,
                                 output logic [255:0] r, output logic [7:0] co);
      int   lw;
      logic c;
      lw = 0;
      if (m == 3'b100) begin
         case (w)
            3'b000:  lw = 32;
            3'b001:  lw = 64;
            3'b011:  lw = 128;
            3'b111:  lw = 256;
            default: lw = 0;
         endcase
      end
      co = '0;
      r  = '0;
      if (lw == 0) begin
         r = p ^ s;
      end else begin
         c = 1'b0;
         for (int i = 0; i < 256; i++) begin
            if (i % lw == 0) c = 1'b0;
            r[i] = p[i] ^ s[i] ^ c;
            c    = (p[i] & s[i]) | (c & (p[i] ^ s[i]));
            if ((i + 1) % lw == 0) co[i/32] = c;
         end
      end
   endfunction

   // Send one beat with out_ready held high. Check the accept-to-valid latency,
   // the result, and err_o one cycle after acceptance.
   task automatic run_one(input string tag, input logic [255:0] p, input logic [255:0] s,
                          input logic [2:0] m, input logic [2:0] w,
                          input logic [255:0] er, input logic [7:0] ec, input logic ee);
      int lat;
      in_valid  = 1'b1;
      ps = p; sc = s; mode = m; width = w;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      chk({tag, "_err"}, 256'(err), 256'(ee));
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
         @(negedge clk);
      end
      chk({tag, "_lat"}, 256'(lat), 256'd4);
      chk({tag, "_res"}, res, er);
      chk({tag, "_cout"}, 256'(cout), 256'(ec));
      tick();
   endtask

   logic [255:0] sp [10];
   logic [255:0] ss [10];
   logic [255:0] er [10];
   logic [2:0]   sm [10];
   logic [2:0]   sw [10];
   logic [7:0]   ec [10];
   logic [5:0]   tbl [6] = '{6'b100_000, 6'b100_001, 6'b010_000, 6'b100_011, 6'b100_111, 6'b010_101};

   initial begin
      int           sent;
      int           recv;
      int           cyc;
      int           extra;
      logic         stall;
      logic [255:0] held_r;
      logic [7:0]   held_c;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      ps = '0; sc = '0; mode = 3'b100; width = 3'b000;
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", 256'(out_valid), 256'd0);
      chk("rst_res", res, 256'd0);
      chk("rst_cout", 256'(cout), 256'd0);
      chk("rst_err", 256'(err), 256'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 256'(in_ready), 256'd1);

      run_one("a32", {8{32'hFFFF_FFFF}}, {8{32'h0000_0001}}, 3'b100, 3'b000,
              256'd0, 8'hFF, 1'b0);
      run_one("a256", {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 3'b100, 3'b111,
              256'h1_0000_0000_0000_0000, 8'h00, 1'b0);
      run_one("a64", {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 3'b100, 3'b001,
              256'd0, 8'b0000_0010, 1'b0);
      run_one("bool", {32{8'hA5}}, {32{8'hFF}}, 3'b010, 3'b000,
              {32{8'h5A}}, 8'h00, 1'b0);
      run_one("a128", {4{64'hFFFF_FFFF_FFFF_FFFF}}, {128'd1, 128'd1}, 3'b100, 3'b011,
              256'd0, 8'h88, 1'b0);
      run_one("a64_mid", {224'h0, 32'hFFFF_FFFF}, 256'd1, 3'b100, 3'b001,
              256'h1_0000_0000, 8'h00, 1'b0);

      // Backpressure stream: mixed modes and widths, random gaps and stalls.
      for (int i = 0; i < 10; i++) begin
         sp[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         ss[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (i % 3 == 0) begin
            sp[i][0] = 1'b1;
            ss[i]    = ~sp[i];
            ss[i][0] = 1'b1;
         end
         {sm[i], sw[i]} = tbl[i % 6];
         model(sp[i], ss[i], sm[i], sw[i], er[i], ec[i]);
      end
      sent = 0; recv = 0; cyc = 0; stall = 1'b0;
      held_r = '0; held_c = '0;
      while (recv < 10 && cyc < 500) begin
         if (sent < 10) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ps = sp[sent]; sc = ss[sent]; mode = sm[sent]; width = sw[sent];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (stall) begin
            chk("stall_valid", 256'(out_valid), 256'd1);
            chk("stall_res", res, held_r);
            chk("stall_cout", 256'(cout), 256'(held_c));
         end
         stall = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (recv < 10) begin
                  chk($sformatf("stream_res%0d", recv), res, er[recv]);
                  chk($sformatf("stream_cout%0d", recv), 256'(cout), 256'(ec[recv]));
               end
               recv++;
            end else begin
               stall  = 1'b1;
               held_r = res;
               held_c = cout;
            end
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      chk("stream_count", 256'(recv), 256'd10);
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) extra++;
         tick();
      end
      chk("stream_extra", 256'(extra), 256'd0);

      // Reset with three beats in flight: none of them may appear.
      in_valid = 1'b1; ps = {8{32'h1234_5678}}; sc = '0; mode = 3'b010; width = 3'b000;
      tick(); tick(); tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("flush_valid", 256'(out_valid), 256'd0);
      rst = 1'b0;
      tick();
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) extra++;
         tick();
      end
      chk("flush_none", 256'(extra), 256'd0);
      chk("pre_illegal_err", 256'(err), 256'd0);

      // Illegal width: treated as boolean, and the error flag is sticky until reset.
      run_one("illegal", {32{8'hA5}}, {32{8'hFF}}, 3'b100, 3'b010,
              {32{8'h5A}}, 8'h00, 1'b1);
      tick(); tick();
      chk("err_sticky", 256'(err), 256'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", 256'(err), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/simd_csa_resolve.md
Name: simd_csa_resolve

Overview:
- Receiving end of the simd_muland carry-save output.
- Takes a (ps, sc) pair per beat and resolves it to a final SIMD result:
  - arithmetic mode: lane-wise sum mod 2^lane_width;
  - boolean mode: XOR share combine.
- The carry-propagate addition is pipelined over 64-bit chunks. Carries are broken at lane boundaries.
- Sits between simd_muland and the correlated-randomness output buffer. Uses a valid/ready handshake.

Parameters:
- W, 256, datapath width in bits. Must be a multiple of 64.
- CHUNK, 64, bits resolved per pipeline stage. The number of stages is NS = W/CHUNK = 4.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- ps_i  in  W  partial-sum vector.
- sc_i  in  W  shifted-carry vector, already aligned.
- mode_i  in  3  3'b100 arithmetic, 3'b010 boolean.
- width_i  in  3  lane width: 3'b000 = 32, 3'b001 = 64, 3'b011 = 128, 3'b111 = 256.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- res_o  out  W  resolved result.
- cout_o  out  W/32  carry-out of each lane. The bit is placed at the index of the lane's most-significant 32-bit segment; all other bits are 0.
- err_o  out  1  sticky error flag: an illegal mode or width was accepted.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - all stage valid bits cleared; out_valid_o = 0;
  - res_o = 0, cout_o = 0, err_o = 0;
  - in_ready_o = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Handshake:
  - An input transfer occurs when in_valid_i & in_ready_o.
  - An output transfer occurs when out_valid_o & out_ready_i.
  - in_ready_o = ~out_valid_o | out_ready_i. This is a global pipeline advance enable and is combinational from out_ready_i.
- Stall: when advance = 0, every stage register (data, valid, mode, width, carry) holds. res_o and cout_o stay stable while out_valid_o = 1 and out_ready_i = 0.
- Bubbles: an idle input cycle with advance = 1 inserts an invalid stage. Bubbles propagate and never assert out_valid_o.
- Pipeline:
  - Stage k (k = 0..NS-1) resolves chunk k (bits 64k+63:64k) using carry_in from stage k-1; carry_in to stage 0 is 0.
  - Chunks not yet resolved are carried forward in the stage registers. Resolved chunks are delayed so that all chunks of a beat exit aligned.
- Latency: exactly NS = 4 advancing cycles from input acceptance to out_valid_o. With out_ready_i held at 1, throughput is 1 beat/cycle.
- Arithmetic mode (3'b100):
  - Carry into bit i is forced to 0 when i is a lane boundary (i mod lane_width = 0). This applies both inside a chunk (32-bit lanes, at bit 32) and between chunks.
  - The carry out of each lane's top bit goes to cout_o and is dropped from res_o.
- Boolean mode (3'b010): res_o = ps_i ^ sc_i; cout_o = 0. width_i is ignored.
- Illegal mode or width on an accepted beat:
  - the beat is processed as boolean;
  - err_o sets on the cycle after acceptance and stays set until reset.
- mode and width travel with each beat, so back-to-back beats may differ in mode and width.
- Simultaneous input and output transfers in one cycle are legal and lossless.

Test Plan:
- Arith, width 32: ps = all lanes 32'hFFFF_FFFF, sc = all lanes 32'h0000_0001 -> res_o = 0, cout_o = 8'hFF, out_valid_o exactly 4 cycles after accept.
- Arith, width 256: ps = {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, sc = 1 -> res_o = 256'h1_0000_0000_0000_0000; the carry crosses the chunk boundary; cout_o = 0.
- Arith, width 64, same stimulus as the previous case -> res_o = 0, cout_o = 8'b0000_0010 (no carry leaks into lane 1).
- Boolean: ps = 256'hA5…A5, sc = 256'hFF…FF -> res_o = 256'h5A…5A, cout_o = 0.
- Backpressure: stream 10 random beats with mixed modes and widths, toggle out_ready_i pseudo-randomly -> all 10 results in order, matching the software model; res_o stable during every stall; no duplicates or drops.
- Reset with 3 beats in flight -> out_valid_o = 0 the next cycle and none of the 3 emitted. Then an illegal width 3'b010 -> boolean result and err_o = 1 until the next rst_i.
